// File: rtl/counter_call_dispatcher.sv
// Purpose: assign the oldest waiting ticket number to the next requesting counter (A..E), round-robin.
// Latency: grant registered one clock after the request/ticket edge is captured; HOLD_CYCLES+1 clocks between grants.
// Backpressure: none; requests stay pending until served, and a ticket issued with the queue full is dropped with ticket_reject.
//
// Ports:
//   clk, rst             single rising-edge clock, synchronous active-low reset
//   ticket_in            ticket issued (level, rising edge counted once)
//   call_req[4:0]        per-counter call request, bit 0 = A .. bit 4 = E (level, rising edge per bit)
//   number_service       most recently called number
//   counter_call         counter that received number_service, 1 = A .. 5 = E, 0 = none
//   call_valid           one-cycle pulse per grant
//   A..E_serviceNumber   number currently served at each counter
//   waiting              issued but not yet called tickets
//   ticket_reject        one-cycle pulse when a ticket is dropped because the queue is full
module counter_call_dispatcher #(
  parameter int NUM_W       = 6,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ticket_in,
  input  logic [4:0]       call_req,
  output logic [NUM_W-1:0] number_service,
  output logic [2:0]       counter_call,
  output logic             call_valid,
  output logic [NUM_W-1:0] A_serviceNumber,
  output logic [NUM_W-1:0] B_serviceNumber,
  output logic [NUM_W-1:0] C_serviceNumber,
  output logic [NUM_W-1:0] D_serviceNumber,
  output logic [NUM_W-1:0] E_serviceNumber,
  output logic [NUM_W-1:0] waiting,
  output logic             ticket_reject
);

  localparam logic [NUM_W-1:0] NUM_MAX   = {NUM_W{1'b1}};
  localparam logic [NUM_W-1:0] NUM_ONE   = NUM_W'(1);
  localparam int               HOLD_W    = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_ANNOUNCE
  } state_e;

  // State and datapath registers
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_W-1:0]  next_call_q, next_call_d;
  logic [NUM_W-1:0]  waiting_q, waiting_d;
  logic [4:0]        pending_q, pending_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic              ticket_prev_q, ticket_prev_d;
  logic [4:0]        req_prev_q, req_prev_d;

  // Output registers
  logic [NUM_W-1:0]  number_q, number_d;
  logic [2:0]        counter_q, counter_d;
  logic              call_valid_q, call_valid_d;
  logic              reject_q, reject_d;
  logic [NUM_W-1:0]  svc_q [5];
  logic [NUM_W-1:0]  svc_d [5];

  // Edge detection against the previous sample
  logic       ticket_edge;
  logic [4:0] req_edge;
  assign ticket_edge = ticket_in & ~ticket_prev_q;
  assign req_edge    = call_req & ~req_prev_q;

  // Cyclic successor over the five counters
  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Round-robin pick: first pending counter strictly after rr_ptr, wrapping.
  // The last candidate visited is rr_ptr itself, so a lone requester still wins.
  logic       grant_hit;
  logic [2:0] grant_idx;
  logic [2:0] cand;

  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 3'd0;
    cand      = rr_ptr_q;
    for (int k = 0; k < 5; k++) begin
      cand = wrap_inc(cand);
      if (!grant_hit && pending_q[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state, datapath and output logic
  logic       grant;
  logic       tix_accept;
  logic [4:0] grant_mask;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    next_call_d   = next_call_q;
    waiting_d     = waiting_q;
    rr_ptr_d      = rr_ptr_q;
    number_d      = number_q;
    counter_d     = counter_q;
    call_valid_d  = 1'b0;
    reject_d      = 1'b0;
    ticket_prev_d = ticket_in;
    req_prev_d    = call_req;
    grant         = 1'b0;
    grant_mask    = 5'b0;
    for (int i = 0; i < 5; i++) begin
      svc_d[i] = svc_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        // Decision uses registered waiting/pending only; same-cycle edges wait a clock.
        if ((waiting_q != '0) && grant_hit) begin
          grant        = 1'b1;
          number_d     = next_call_q;
          counter_d    = grant_idx + 3'd1;
          call_valid_d = 1'b1;
          rr_ptr_d     = grant_idx;
          next_call_d  = (next_call_q == NUM_MAX) ? NUM_ONE : next_call_q + NUM_ONE;
          hold_cnt_d   = HOLD_INIT;
          state_d      = ST_ANNOUNCE;
        end
      end
      ST_ANNOUNCE: begin
        hold_cnt_d = hold_cnt_q - HOLD_ONE;
        if (hold_cnt_q == HOLD_ONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int i = 0; i < 5; i++) begin
      if (grant && (grant_idx == 3'(i))) begin
        grant_mask[i] = 1'b1;
        svc_d[i]      = next_call_q;
      end
    end

    // A request edge on a counter being granted this cycle is absorbed by that grant.
    pending_d = (pending_q | req_edge) & ~grant_mask;

    // Full check uses the pre-update count, so a grant in the same cycle does not
    // rescue a ticket that arrived while the queue was full.
    tix_accept = ticket_edge && (waiting_q != NUM_MAX);
    reject_d   = ticket_edge && (waiting_q == NUM_MAX);

    case ({tix_accept, grant})
      2'b10:   waiting_d = waiting_q + NUM_ONE;
      2'b01:   waiting_d = waiting_q - NUM_ONE;
      default: waiting_d = waiting_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      next_call_q   <= NUM_ONE;
      waiting_q     <= '0;
      pending_q     <= '0;
      rr_ptr_q      <= 3'd4;
      ticket_prev_q <= 1'b0;
      req_prev_q    <= '0;
      number_q      <= '0;
      counter_q     <= '0;
      call_valid_q  <= 1'b0;
      reject_q      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        svc_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      next_call_q   <= next_call_d;
      waiting_q     <= waiting_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      ticket_prev_q <= ticket_prev_d;
      req_prev_q    <= req_prev_d;
      number_q      <= number_d;
      counter_q     <= counter_d;
      call_valid_q  <= call_valid_d;
      reject_q      <= reject_d;
      for (int i = 0; i < 5; i++) begin
        svc_q[i] <= svc_d[i];
      end
    end
  end

  assign number_service  = number_q;
  assign counter_call    = counter_q;
  assign call_valid      = call_valid_q;
  assign ticket_reject   = reject_q;
  assign waiting         = waiting_q;
  assign A_serviceNumber = svc_q[0];
  assign B_serviceNumber = svc_q[1];
  assign C_serviceNumber = svc_q[2];
  assign D_serviceNumber = svc_q[3];
  assign E_serviceNumber = svc_q[4];

endmodule

// File: tb/tb_counter_call_dispatcher.sv
// Purpose: self-checking bench for counter_call_dispatcher (vector table + grant scoreboard).
// Latency: expected grants queued at stimulus time, popped when call_valid is seen.
// Backpressure: n/a; every wait on the DUT is bounded.
module tb_counter_call_dispatcher;

  localparam int NUM_W = 6;
  localparam int HOLD  = 2;
  localparam int GAP   = HOLD + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ticket_in;
  logic [4:0]       call_req;
  logic [NUM_W-1:0] number_service;
  logic [2:0]       counter_call;
  logic             call_valid;
  logic [NUM_W-1:0] a_svc, b_svc, c_svc, d_svc, e_svc;
  logic [NUM_W-1:0] waiting;
  logic             ticket_reject;

  counter_call_dispatcher #(.NUM_W(NUM_W), .HOLD_CYCLES(HOLD)) dut (
    .clk             (clk),
    .rst             (rst),
    .ticket_in       (ticket_in),
    .call_req        (call_req),
    .number_service  (number_service),
    .counter_call    (counter_call),
    .call_valid      (call_valid),
    .A_serviceNumber (a_svc),
    .B_serviceNumber (b_svc),
    .C_serviceNumber (c_svc),
    .D_serviceNumber (d_svc),
    .E_serviceNumber (e_svc),
    .waiting         (waiting),
    .ticket_reject   (ticket_reject)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int grant_cnt = 0;
  int last_grant_cyc = 0;

  typedef struct {
    int ctr;
    int num;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   exp_svc[5];

  typedef struct {
    int         n_tix;
    logic [4:0] req;
    int         exp_grants;
    int         exp_wait;
  } vec_t;

  vec_t vecs[6];

  function automatic int svc_of(input int c);
    case (c)
      1: return int'(a_svc);
      2: return int'(b_svc);
      3: return int'(c_svc);
      4: return int'(d_svc);
      5: return int'(e_svc);
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every call_valid must match the oldest expected grant.
  always @(negedge clk) begin
    if (call_valid) begin
      grant_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_grant: got counter %0d number %0d, expected no grant",
                 counter_call, number_service);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_counter", int'(counter_call), mon_e.ctr);
        check("grant_number", int'(number_service), mon_e.num);
        check("grant_svc", svc_of(mon_e.ctr), mon_e.num);
        if (mon_e.gap != 0) check("grant_gap", cyc - last_grant_cyc, mon_e.gap);
      end
      last_grant_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_call_valid"}, int'(call_valid), 0);
    check({tag, "_number"}, int'(number_service), 0);
    check({tag, "_counter"}, int'(counter_call), 0);
    check({tag, "_waiting"}, int'(waiting), 0);
    check({tag, "_reject"}, int'(ticket_reject), 0);
    for (int i = 1; i <= 5; i++) check($sformatf("%s_svc%0d", tag, i), svc_of(i), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    ticket_in = 1'b0;
    call_req  = 5'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) exp_svc[i] = 0;
  endtask

  task automatic pulse_ticket();
    ticket_in = 1'b1;
    tick();
    ticket_in = 1'b0;
    tick();
  endtask

  task automatic push_exp(input int ctr, input int num, input int gap);
    exp_t e;
    e.ctr = ctr;
    e.num = num;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d grants outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int b;
    rst       = 1'b0;
    ticket_in = 1'b0;
    call_req  = 5'b0;

    // tickets, simultaneous request mask, expected grant count, expected waiting after
    vecs[0] = '{2, 5'b00001, 1, 1};
    vecs[1] = '{3, 5'b10101, 3, 0};
    vecs[2] = '{5, 5'b11111, 5, 0};
    vecs[3] = '{2, 5'b11010, 2, 0};
    vecs[4] = '{0, 5'b00100, 0, 0};
    vecs[5] = '{4, 5'b01000, 1, 3};

    for (int r = 0; r < 6; r++) begin
      do_reset();
      grant_cnt = 0;
      for (int t = 0; t < vecs[r].n_tix; t++) pulse_ticket();
      // From reset, A has first priority, so order is ascending bit position.
      g = 0;
      for (int i = 0; i < 5; i++) begin
        if (vecs[r].req[i] && g < vecs[r].n_tix) begin
          push_exp(i + 1, g + 1, (g == 0) ? 0 : GAP);
          exp_svc[i] = g + 1;
          g++;
        end
      end
      call_req = vecs[r].req;
      tick();
      tick();
      call_req = 5'b0;
      drain(60);
      repeat (4) tick();
      check($sformatf("vec%0d_grants", r), grant_cnt, vecs[r].exp_grants);
      check($sformatf("vec%0d_waiting", r), int'(waiting), vecs[r].exp_wait);
      for (int i = 0; i < 5; i++)
        check($sformatf("vec%0d_svc%0d", r, i + 1), svc_of(i + 1), exp_svc[i]);
    end

    // Request latency: edge at N, grant visible after N+1.
    do_reset();
    pulse_ticket();
    tick();
    push_exp(1, 1, 0);
    call_req = 5'b00001;
    tick();
    check("req_lat_edge_n", int'(call_valid), 0);
    tick();
    check("req_lat_edge_n1", int'(call_valid), 1);
    check("req_lat_waiting", int'(waiting), 0);
    call_req = 5'b0;
    drain(10);

    // B waits on an empty queue; ticket arrives 5 cycles later.
    do_reset();
    call_req = 5'b00010;
    tick();
    call_req = 5'b0;
    repeat (4) tick();
    push_exp(2, 1, 0);
    ticket_in = 1'b1;
    tick();
    check("tix_lat_edge_n", int'(call_valid), 0);
    tick();
    check("tix_lat_edge_n1", int'(call_valid), 1);
    check("tix_lat_counter", int'(counter_call), 2);
    check("tix_lat_waiting", int'(waiting), 0);
    ticket_in = 1'b0;
    drain(10);

    // Queue full: 63 accepted, the 64th rejected.
    do_reset();
    for (int t = 0; t < 63; t++) pulse_ticket();
    check("full_waiting", int'(waiting), 63);
    check("full_no_reject", int'(ticket_reject), 0);
    ticket_in = 1'b1;
    tick();
    check("full_reject_pulse", int'(ticket_reject), 1);
    check("full_waiting_held", int'(waiting), 63);
    ticket_in = 1'b0;
    tick();
    check("full_reject_one_cycle", int'(ticket_reject), 0);

    // Ticket while full in the same cycle as a grant: still rejected, waiting decrements.
    push_exp(1, 1, 0);
    call_req = 5'b00001;
    tick();
    ticket_in = 1'b1;
    tick();
    check("full_grant_valid", int'(call_valid), 1);
    check("full_grant_reject", int'(ticket_reject), 1);
    check("full_grant_waiting", int'(waiting), 62);
    call_req  = 5'b0;
    ticket_in = 1'b0;
    tick();
    repeat (4) tick();

    // Serve the rest (numbers 2..63), then the next number wraps to 1.
    for (int n = 2; n <= 63; n++) begin
      push_exp(1, n, 0);
      call_req = 5'b00001;
      tick();
      call_req = 5'b0;
      repeat (4) tick();
    end
    drain(10);
    check("wrap_waiting", int'(waiting), 0);
    check("wrap_last_number", int'(number_service), 63);
    push_exp(1, 1, 0);
    pulse_ticket();
    call_req = 5'b00001;
    tick();
    call_req = 5'b0;
    drain(10);
    check("wrap_a_svc", int'(a_svc), 1);

    // Reset during ANNOUNCE discards the remaining requests and tickets.
    do_reset();
    repeat (3) pulse_ticket();
    push_exp(1, 1, 0);
    call_req = 5'b10101;
    b = 0;
    while (!call_valid && b < 10) begin
      tick();
      b++;
    end
    check("midrst_grant_seen", int'(call_valid), 1);
    call_req = 5'b0;
    rst      = 1'b0;
    tick();
    check_zero("midrst");
    rst = 1'b1;
    repeat (6) tick();
    check("midrst_waiting_after", int'(waiting), 0);
    push_exp(3, 1, 0);
    pulse_ticket();
    call_req = 5'b00100;
    tick();
    call_req = 5'b0;
    drain(10);
    check("midrst_c_svc", int'(c_svc), 1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
